// File: rtl/branch_tracker_queue_pkg.sv
// -----------------------------------------------------------------------------
// branch_tracker_queue_pkg
// Shared types and default sizing for the branch tracker queue.
//   btq_entry_t   : one in-flight branch record (rob index, predicted and
//                   resolved next PC, resolution and mispredict flags)
//   BTQ_*         : default queue parameters derived from core-wide constants
//   btq_new_entry : builds a freshly dispatched, unresolved entry
// No ports (package).
// -----------------------------------------------------------------------------
package branch_tracker_queue_pkg;

  // Core-wide constants the queue defaults are derived from.
  localparam int CORE_ISSUE_WIDTH = 2;
  localparam int CORE_CDB_PORTS   = 2;
  localparam int CORE_ROB_ENTRIES = 32;
  localparam int CORE_PC_W        = 32;

  localparam int BTQ_SS       = CORE_ISSUE_WIDTH;
  localparam int BTQ_NUM_CDB  = CORE_CDB_PORTS;
  localparam int BTQ_DEPTH    = 8;
  localparam int BTQ_ROB_BITS = $clog2(CORE_ROB_ENTRIES);
  localparam int BTQ_PC_W     = CORE_PC_W;

  // The entry record is sized by the core-wide widths; the queue's ROB_BITS
  // and PC_W parameters are expected to match them.
  typedef struct packed {
    logic [BTQ_ROB_BITS-1:0] rob_idx;
    logic [BTQ_PC_W-1:0]     pred_pc;
    logic [BTQ_PC_W-1:0]     tgt_pc;
    logic                    resolved;
    logic                    mispred;
  } btq_entry_t;

  function automatic btq_entry_t btq_new_entry(
    input logic [BTQ_ROB_BITS-1:0] rob,
    input logic [BTQ_PC_W-1:0]     pred
  );
    btq_entry_t e;
    e.rob_idx  = rob;
    e.pred_pc  = pred;
    e.tgt_pc   = {BTQ_PC_W{1'b0}};
    e.resolved = 1'b0;
    e.mispred  = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/branch_tracker_queue_if.sv
// -----------------------------------------------------------------------------
// branch_tracker_queue_if
// Bundles every dispatch, CDB, commit, flush and redirect signal of the
// branch tracker queue.
//   master : the surrounding core (drives push/cdb/commit/flush, reads status)
//   slave  : the queue itself
// Signals:
//   push_cnt/push_rob/push_pred      dispatch of up to SS branches
//   cdb_valid/cdb_rob/cdb_target     NUM_CDB resolve broadcasts
//   commit_cnt/commit_rob            ROB retirement window
//   flush_all/flush_part/flush_rob   recovery
//   redir_valid/redir_rob/redir_pc   oldest mispredicted branch
//   num_free/empty                   occupancy status
// -----------------------------------------------------------------------------
interface branch_tracker_queue_if #(
  parameter int SS       = branch_tracker_queue_pkg::BTQ_SS,
  parameter int NUM_CDB  = branch_tracker_queue_pkg::BTQ_NUM_CDB,
  parameter int DEPTH    = branch_tracker_queue_pkg::BTQ_DEPTH,
  parameter int ROB_BITS = branch_tracker_queue_pkg::BTQ_ROB_BITS,
  parameter int PC_W     = branch_tracker_queue_pkg::BTQ_PC_W
);

  localparam int CW    = $clog2(SS) + 1;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [CW-1:0]       push_cnt;
  logic [ROB_BITS-1:0] push_rob   [SS];
  logic [PC_W-1:0]     push_pred  [SS];
  logic                cdb_valid  [NUM_CDB];
  logic [ROB_BITS-1:0] cdb_rob    [NUM_CDB];
  logic [PC_W-1:0]     cdb_target [NUM_CDB];
  logic [CW-1:0]       commit_cnt;
  logic [ROB_BITS-1:0] commit_rob;
  logic                flush_all;
  logic                flush_part;
  logic [ROB_BITS-1:0] flush_rob;
  logic                redir_valid;
  logic [ROB_BITS-1:0] redir_rob;
  logic [PC_W-1:0]     redir_pc;
  logic [PTR_W-1:0]    num_free;
  logic                empty;

  modport master (
    output push_cnt, push_rob, push_pred,
    output cdb_valid, cdb_rob, cdb_target,
    output commit_cnt, commit_rob,
    output flush_all, flush_part, flush_rob,
    input  redir_valid, redir_rob, redir_pc, num_free, empty
  );

  modport slave (
    input  push_cnt, push_rob, push_pred,
    input  cdb_valid, cdb_rob, cdb_target,
    input  commit_cnt, commit_rob,
    input  flush_all, flush_part, flush_rob,
    output redir_valid, redir_rob, redir_pc, num_free, empty
  );

endinterface

// File: rtl/branch_tracker_queue_age_scan.sv
// -----------------------------------------------------------------------------
// btq_age_scan
// Oldest-first priority finder. Bit 0 of req is the oldest position.
//   req   in  N   request per age position
//   found out 1   any request set
//   idx   out IW  age position of the oldest request (0 when none)
// -----------------------------------------------------------------------------
module btq_age_scan #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk from oldest to youngest and latch the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      idx   = (req[j] && !found) ? IW'(j) : idx;
      found = found | req[j];
    end
  end

endmodule

// File: rtl/branch_tracker_queue_chk.sv
// -----------------------------------------------------------------------------
// btq_checker
// Protocol checks on the dispatch side of the branch tracker queue.
//   clk, rst  : clock and synchronous reset (checks idle during reset)
//   push_cnt  : branches offered this cycle
//   num_free  : free entries seen by dispatch this cycle
// -----------------------------------------------------------------------------
module btq_checker #(
  parameter int CW    = 2,
  parameter int PTR_W = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [CW-1:0]    push_cnt,
  input logic [PTR_W-1:0] num_free
);

  // Dispatch must never offer more branches than there are free entries.
  a_push_fits : assert property (@(posedge clk) disable iff (rst)
    (PTR_W'(push_cnt) <= num_free));

endmodule

// File: rtl/branch_tracker_queue.sv
// -----------------------------------------------------------------------------
// branch_tracker_queue
// In-order circular queue of in-flight branches. Records predicted and
// resolved targets, supports full and partial (younger-than) squash, and
// presents the oldest known mispredicted branch as a redirect candidate.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears the queue
//   bus  : branch_tracker_queue_if.slave (dispatch, CDB, commit, flush,
//          redirect and occupancy signals)
// All outputs are decoded from registered state only. DEPTH must be a power
// of two, at least 2, and at least SS.
// -----------------------------------------------------------------------------
module branch_tracker_queue
  import branch_tracker_queue_pkg::*;
#(
  parameter int SS       = BTQ_SS,
  parameter int NUM_CDB  = BTQ_NUM_CDB,
  parameter int DEPTH    = BTQ_DEPTH,
  parameter int ROB_BITS = BTQ_ROB_BITS,
  parameter int PC_W     = BTQ_PC_W
) (
  input logic                  clk,
  input logic                  rst,
  branch_tracker_queue_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CW    = $clog2(SS) + 1;

  btq_entry_t       mem      [DEPTH];
  btq_entry_t       mem_nxt  [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;

  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] free_cnt;
  logic [AW-1:0]    age_slot  [DEPTH];
  logic [DEPTH-1:0] age_live;
  logic [DEPTH-1:0] slot_live;
  logic [DEPTH-1:0] redir_req;
  logic [DEPTH-1:0] flush_req;
  logic             redir_found;
  logic [AW-1:0]    redir_pos;
  logic             flush_found;
  logic [AW-1:0]    flush_pos;
  logic [CW-1:0]    pop_k;
  logic             scanning;
  logic             commit_hit;
  logic             push_en;
  logic             cdb_hit;
  logic             push_wr;
  logic [AW-1:0]    push_slot;
  logic [AW-1:0]    slot_off;

  // The pointer MSB separates full from empty, so plain subtraction is exact.
  assign occ      = tail - head;
  assign free_cnt = PTR_W'(DEPTH) - occ;

  assign bus.num_free = free_cnt;
  assign bus.empty    = (occ == '0);

  // Age-ordered view of the ring: position j is the j-th oldest entry.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      age_slot[j]  = head[AW-1:0] + AW'(j);
      age_live[j]  = (PTR_W'(j) < occ);
      redir_req[j] = age_live[j] & mem[age_slot[j]].resolved & mem[age_slot[j]].mispred;
      flush_req[j] = age_live[j] &
                     (mem[age_slot[j]].rob_idx == BTQ_ROB_BITS'(bus.flush_rob));
    end
  end

  // Physical-slot liveness, used where updates are indexed by storage slot.
  always_comb begin
    slot_off = '0;
    for (int e = 0; e < DEPTH; e++) begin
      slot_off     = AW'(e) - head[AW-1:0];
      slot_live[e] = ({1'b0, slot_off} < occ);
    end
  end

  btq_age_scan #(.N(DEPTH), .IW(AW)) u_redir_scan (
    .req   (redir_req),
    .found (redir_found),
    .idx   (redir_pos)
  );

  btq_age_scan #(.N(DEPTH), .IW(AW)) u_flush_scan (
    .req   (flush_req),
    .found (flush_found),
    .idx   (flush_pos)
  );

  // Redirect candidate: oldest resolved-and-mispredicted entry, zero if none.
  always_comb begin
    if (redir_found) begin
      bus.redir_valid = 1'b1;
      bus.redir_rob   = ROB_BITS'(mem[age_slot[redir_pos]].rob_idx);
      bus.redir_pc    = PC_W'(mem[age_slot[redir_pos]].tgt_pc);
    end else begin
      bus.redir_valid = 1'b0;
      bus.redir_rob   = '0;
      bus.redir_pc    = '0;
    end
  end

  // Pop count: leading entries covered by the commit window; stops at the
  // first entry that is not retiring.
  always_comb begin
    pop_k      = '0;
    scanning   = 1'b1;
    commit_hit = 1'b0;
    for (int j = 0; j < SS; j++) begin
      commit_hit = 1'b0;
      for (int i = 0; i < SS; i++) begin
        commit_hit = commit_hit | ((CW'(i) < bus.commit_cnt) &
                     (mem[age_slot[j]].rob_idx ==
                      BTQ_ROB_BITS'(bus.commit_rob + ROB_BITS'(i))));
      end
      scanning = scanning & age_live[j] & commit_hit;
      pop_k    = pop_k + CW'(scanning);
    end
  end

  // A push is taken only when it fits and no partial squash is in progress.
  assign push_en = !bus.flush_part && (PTR_W'(bus.push_cnt) <= free_cnt);

  // Next entry contents: CDB resolves first, then push data overwrites, so a
  // freshly pushed slot never inherits a stale resolve.
  always_comb begin
    mem_nxt   = mem;
    cdb_hit   = 1'b0;
    push_wr   = 1'b0;
    push_slot = '0;
    for (int e = 0; e < DEPTH; e++) begin
      // Ascending port order lets the higher port win on duplicate rob ids.
      for (int c = 0; c < NUM_CDB; c++) begin
        cdb_hit = bus.cdb_valid[c] && slot_live[e] &&
                  (mem[e].rob_idx == BTQ_ROB_BITS'(bus.cdb_rob[c]));
        mem_nxt[e].tgt_pc   = cdb_hit ? BTQ_PC_W'(bus.cdb_target[c]) : mem_nxt[e].tgt_pc;
        mem_nxt[e].resolved = cdb_hit ? 1'b1 : mem_nxt[e].resolved;
        mem_nxt[e].mispred  = cdb_hit ? (BTQ_PC_W'(bus.cdb_target[c]) != mem[e].pred_pc)
                                      : mem_nxt[e].mispred;
      end
      for (int i = 0; i < SS; i++) begin
        push_slot  = tail[AW-1:0] + AW'(i);
        push_wr    = push_en && (CW'(i) < bus.push_cnt) && (push_slot == AW'(e));
        mem_nxt[e] = push_wr ? btq_new_entry(BTQ_ROB_BITS'(bus.push_rob[i]),
                                             BTQ_PC_W'(bus.push_pred[i]))
                             : mem_nxt[e];
      end
    end
  end

  // Next pointers. A partial squash truncates the tail just past the matching
  // survivor (or leaves it alone) and drops that cycle's pushes.
  always_comb begin
    head_nxt = head + PTR_W'(pop_k);
    if (bus.flush_part) begin
      if (flush_found) begin
        tail_nxt = head + PTR_W'(flush_pos) + PTR_W'(1'b1);
      end else begin
        tail_nxt = tail;
      end
    end else if (push_en) begin
      tail_nxt = tail + PTR_W'(bus.push_cnt);
    end else begin
      tail_nxt = tail;
    end
  end

  // State register; reset and flush_all both clear pointers and contents.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_all) begin
      head <= '0;
      tail <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= mem_nxt[e];
      end
    end
  end

  btq_checker #(.CW(CW), .PTR_W(PTR_W)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .push_cnt (bus.push_cnt),
    .num_free (free_cnt)
  );

endmodule

// File: tb/tb_branch_tracker_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_tracker_queue
// Directed and random stimulus for branch_tracker_queue, compared every cycle
// against a queue-based reference model of the branch list.
// -----------------------------------------------------------------------------
module tb_branch_tracker_queue;

  localparam int SS       = 2;
  localparam int NUM_CDB  = 2;
  localparam int DEPTH    = 8;
  localparam int ROB_BITS = 5;
  localparam int PC_W     = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   next_rob   = 0;

  always #5 clk = ~clk;

  branch_tracker_queue_if #(.SS(SS), .NUM_CDB(NUM_CDB), .DEPTH(DEPTH),
                            .ROB_BITS(ROB_BITS), .PC_W(PC_W)) bus ();

  branch_tracker_queue #(.SS(SS), .NUM_CDB(NUM_CDB), .DEPTH(DEPTH),
                         .ROB_BITS(ROB_BITS), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  rob;
    logic [31:0] pred;
    logic [31:0] tgt;
    bit          res;
    bit          mis;
  } m_ent_t;

  m_ent_t mq[$];   // reference list, oldest first

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.push_cnt   = '0;
    bus.commit_cnt = '0;
    bus.commit_rob = '0;
    bus.flush_all  = 1'b0;
    bus.flush_part = 1'b0;
    bus.flush_rob  = '0;
    for (int i = 0; i < SS; i++) begin
      bus.push_rob[i]  = '0;
      bus.push_pred[i] = '0;
    end
    for (int c = 0; c < NUM_CDB; c++) begin
      bus.cdb_valid[c]  = 1'b0;
      bus.cdb_rob[c]    = '0;
      bus.cdb_target[c] = '0;
    end
  endtask

  task automatic set_push(input int n, input int r0, input logic [31:0] p0,
                          input int r1, input logic [31:0] p1);
    bus.push_cnt     = 2'(n);
    bus.push_rob[0]  = 5'(r0);
    bus.push_pred[0] = p0;
    bus.push_rob[1]  = 5'(r1);
    bus.push_pred[1] = p1;
  endtask

  task automatic set_cdb(input int port, input int rob, input logic [31:0] tgt);
    bus.cdb_valid[port]  = 1'b1;
    bus.cdb_rob[port]    = 5'(rob);
    bus.cdb_target[port] = tgt;
  endtask

  task automatic set_commit(input int n, input int rob);
    bus.commit_cnt = 2'(n);
    bus.commit_rob = 5'(rob);
  endtask

  // Reference behaviour for one clock, from the list semantics.
  task automatic model_apply();
    int k;
    int p;
    int free;
    bit hit;
    bit go;
    if (rst || bus.flush_all) begin
      mq.delete();
      return;
    end
    for (int c = 0; c < NUM_CDB; c++) begin
      if (bus.cdb_valid[c]) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].rob == bus.cdb_rob[c]) begin
            mq[j].tgt = bus.cdb_target[c];
            mq[j].res = 1'b1;
            mq[j].mis = (bus.cdb_target[c] != mq[j].pred);
          end
        end
      end
    end
    k  = 0;
    go = 1'b1;
    for (int j = 0; j < SS; j++) begin
      if (j >= mq.size()) go = 1'b0;
      if (go) begin
        hit = 1'b0;
        for (int i = 0; i < int'(bus.commit_cnt); i++)
          if (mq[j].rob == 5'(bus.commit_rob + i)) hit = 1'b1;
        if (!hit) go = 1'b0;
      end
      if (go) k++;
    end
    p = -1;
    if (bus.flush_part)
      for (int j = mq.size() - 1; j >= 0; j--)
        if (mq[j].rob == bus.flush_rob) p = j;
    free = DEPTH - mq.size();
    for (int j = 0; j < k; j++) void'(mq.pop_front());
    if (bus.flush_part) begin
      if (p >= 0)
        while (mq.size() > p + 1 - k) void'(mq.pop_back());
    end else if (int'(bus.push_cnt) <= free) begin
      for (int i = 0; i < int'(bus.push_cnt); i++)
        mq.push_back('{bus.push_rob[i], bus.push_pred[i], 32'h0, 1'b0, 1'b0});
    end
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    logic [4:0]  er;
    logic [31:0] ep;
    ev = 1'b0;
    er = '0;
    ep = '0;
    foreach (mq[j]) begin
      if (!ev && mq[j].res && mq[j].mis) begin
        ev = 1'b1;
        er = mq[j].rob;
        ep = mq[j].tgt;
      end
    end
    chk({tag, ".redir_valid"}, 32'(bus.redir_valid), 32'(ev));
    chk({tag, ".redir_rob"},   32'(bus.redir_rob),   32'(er));
    chk({tag, ".redir_pc"},    bus.redir_pc,         ep);
    chk({tag, ".num_free"},    32'(bus.num_free),    32'(DEPTH - mq.size()));
    chk({tag, ".empty"},       32'(bus.empty),       32'(mq.size() == 0));
  endtask

  task automatic cycle(input string tag);
    model_apply();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    int r;
    int n;
    int free;
    int idx;

    // Reset.
    idle();
    rst = 1'b1;
    cycle("reset");
    cycle("reset2");
    chk("rst_num_free", 32'(bus.num_free), 32'd8);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_redir", 32'(bus.redir_valid), 32'd0);
    rst = 1'b0;

    // Two pushes.
    idle(); set_push(2, 3, 32'h100, 4, 32'h200); cycle("push2");
    chk("push2_free", 32'(bus.num_free), 32'd6);
    chk("push2_empty", 32'(bus.empty), 32'd0);
    chk("push2_redir", 32'(bus.redir_valid), 32'd0);

    // Resolves and redirect selection.
    idle(); set_cdb(0, 4, 32'h240); cycle("cdb4");
    idle(); set_cdb(0, 3, 32'h100); cycle("cdb3ok");
    chk("redir4_valid", 32'(bus.redir_valid), 32'd1);
    chk("redir4_rob", 32'(bus.redir_rob), 32'd4);
    chk("redir4_pc", bus.redir_pc, 32'h240);
    idle(); set_cdb(1, 3, 32'h180); cycle("cdb3bad");
    chk("redir3_rob", 32'(bus.redir_rob), 32'd3);
    chk("redir3_pc", bus.redir_pc, 32'h180);
    idle(); set_commit(2, 3); cycle("commit34");
    chk("commit34_empty", 32'(bus.empty), 32'd1);

    // Walk the pointers up to slot DEPTH-1, then fill across the wrap.
    idle(); set_push(2, 5, 32'h50, 6, 32'h60); cycle("adv_a");
    idle(); set_push(2, 7, 32'h70, 8, 32'h80); cycle("adv_b");
    idle(); set_push(1, 9, 32'h90, 0, 32'h0);  cycle("adv_c");
    idle(); set_commit(2, 5); cycle("adv_d");
    idle(); set_commit(2, 7); cycle("adv_e");
    idle(); set_commit(1, 9); cycle("adv_f");
    idle(); set_push(2, 10, 32'ha0, 11, 32'hb0); cycle("wrap_a");
    idle(); set_push(2, 12, 32'hc0, 13, 32'hd0); cycle("wrap_b");
    idle(); set_push(2, 14, 32'he0, 15, 32'hf0); cycle("wrap_c");
    chk("wrap_free6", 32'(bus.num_free), 32'd2);
    idle(); set_push(2, 16, 32'h100, 17, 32'h110); set_commit(2, 10); cycle("push_pop");
    chk("push_pop_free", 32'(bus.num_free), 32'd2);
    idle(); set_push(2, 18, 32'h120, 19, 32'h130); cycle("full");
    chk("full_free", 32'(bus.num_free), 32'd0);
    chk("full_empty", 32'(bus.empty), 32'd0);
    idle(); set_cdb(0, 15, 32'h1); cycle("mis15");
    chk("mis15_rob", 32'(bus.redir_rob), 32'd15);
    idle(); set_commit(2, 12); cycle("pop12");
    chk("pop12_free", 32'(bus.num_free), 32'd2);
    idle(); set_commit(2, 14); cycle("pop14");
    chk("pop14_free", 32'(bus.num_free), 32'd4);
    chk("pop14_redir", 32'(bus.redir_valid), 32'd0);
    idle(); bus.flush_all = 1'b1; cycle("fa1");

    // Partial squash with concurrent push.
    idle(); set_push(2, 10, 32'h10, 11, 32'h11); cycle("fp_a");
    idle(); set_push(2, 12, 32'h12, 13, 32'h13); cycle("fp_b");
    idle(); set_push(1, 14, 32'h14, 0, 32'h0);   cycle("fp_c");
    idle(); set_push(2, 15, 32'h15, 16, 32'h16);
    bus.flush_part = 1'b1; bus.flush_rob = 5'd11; cycle("fp_hit");
    chk("fp_hit_free", 32'(bus.num_free), 32'd6);
    idle(); set_push(1, 17, 32'h17, 0, 32'h0);
    bus.flush_part = 1'b1; bus.flush_rob = 5'd30; cycle("fp_miss");
    chk("fp_miss_free", 32'(bus.num_free), 32'd6);
    idle(); bus.flush_all = 1'b1; cycle("fa2");

    // Pop scan stops at the first non-retiring entry.
    idle(); set_push(2, 9, 32'h90, 12, 32'hc0); cycle("k_setup");
    idle(); set_commit(2, 7); cycle("k0");
    chk("k0_free", 32'(bus.num_free), 32'd6);
    idle(); set_commit(2, 9); cycle("k1");
    chk("k1_free", 32'(bus.num_free), 32'd7);

    // flush_all and rst override concurrent push and CDB.
    idle(); set_cdb(0, 12, 32'h999); cycle("mis12");
    chk("mis12_valid", 32'(bus.redir_valid), 32'd1);
    idle(); set_push(2, 20, 32'h200, 21, 32'h210); set_cdb(1, 12, 32'h777);
    bus.flush_all = 1'b1; cycle("fa3");
    chk("fa3_empty", 32'(bus.empty), 32'd1);
    chk("fa3_free", 32'(bus.num_free), 32'd8);
    chk("fa3_redir", 32'(bus.redir_valid), 32'd0);
    idle(); set_push(2, 20, 32'h200, 21, 32'h210); cycle("rs_a");
    idle(); set_cdb(0, 20, 32'h5); cycle("rs_b");
    idle(); set_push(2, 22, 32'h220, 23, 32'h230); set_cdb(1, 21, 32'h6);
    rst = 1'b1; cycle("rst_mid");
    rst = 1'b0;
    chk("rst_mid_empty", 32'(bus.empty), 32'd1);
    chk("rst_mid_free", 32'(bus.num_free), 32'd8);
    chk("rst_mid_redir", 32'(bus.redir_valid), 32'd0);

    // Random traffic against the reference list.
    next_rob = 0;
    for (int t = 0; t < 400; t++) begin
      idle();
      r    = $urandom_range(0, 99);
      free = DEPTH - mq.size();
      if (r < 3) begin
        bus.flush_all = 1'b1;
      end else if (r < 10) begin
        bus.flush_part = 1'b1;
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
          idx = $urandom_range(0, mq.size() - 1);
          bus.flush_rob = mq[idx].rob;
        end else begin
          bus.flush_rob = 5'($urandom);
        end
      end
      n = $urandom_range(0, SS);
      if (n > free) n = free;
      bus.push_cnt = 2'(n);
      for (int i = 0; i < n; i++) begin
        bus.push_rob[i]  = 5'(next_rob);
        bus.push_pred[i] = $urandom;
        next_rob++;
      end
      if (!bus.flush_part) begin
        bus.commit_cnt = 2'($urandom_range(0, SS));
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) bus.commit_rob = mq[0].rob;
        else bus.commit_rob = 5'($urandom);
      end
      for (int c = 0; c < NUM_CDB; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.cdb_valid[c] = 1'b1;
          if (mq.size() > 0) begin
            idx = $urandom_range(0, mq.size() - 1);
            bus.cdb_rob[c]    = mq[idx].rob;
            bus.cdb_target[c] = ($urandom_range(0, 1) == 1) ? mq[idx].pred : $urandom;
          end else begin
            bus.cdb_rob[c]    = 5'($urandom);
            bus.cdb_target[c] = $urandom;
          end
        end
      end
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
